// File: rtl/ecg_phase_align_if.sv
// AXI-Stream style bundle shared by the multi-lane input side and the wide output side
// of the ECG phase aligner; valid/ready width and data width are set per instance.
interface ecg_phase_align_if #(
    parameter int VALID_W = 1,
    parameter int TDATA_W = 32
);
    logic [VALID_W-1:0] tvalid;
    logic [TDATA_W-1:0] tdata;
    logic [VALID_W-1:0] tready;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/ecg_phase_align.sv
// Per-channel programmable sample delay: each channel buffers into its own circular RAM and
// one aligned frame is emitted per sample once every channel has data or pending padding.
module ecg_phase_align #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int DLY_W  = 10
) (
    input  logic                   sys_clock,
    input  logic                   reset_n,
    input  logic [N_CH*DLY_W-1:0]  cfg_delay,
    input  logic                   cfg_load,
    ecg_phase_align_if.slave       s_axis,
    ecg_phase_align_if.master      m_axis,
    output logic [15:0]            frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t                  state, state_nxt;
    logic                    fetch;
    logic                    handshake;
    logic                    frame_ok;
    logic [N_CH-1:0]         ch_ok;
    logic [N_CH-1:0]         tready_w;
    logic [N_CH*DATA_W-1:0]  frame_data;

    assign s_axis.tready = tready_w;
    assign frame_ok      = &ch_ok;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_data;
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [OW-1:0]     occ;
        logic [DLY_W-1:0]  pad;
        logic              push;
        logic              pop;

        // Ready is held low while reset is asserted and otherwise reflects free space.
        assign tready_w[c] = reset_n & (occ < OW'(DEPTH));
        assign push        = s_axis.tvalid[c] & tready_w[c] & ~cfg_load;
        assign pop         = fetch & (pad == '0);
        assign ch_ok[c]    = (pad != '0) | (occ != '0);
        assign frame_data[c*DATA_W +: DATA_W] = (pad != '0) ? DATA_W'(0) : rd_data;

        // NOTE: the sample RAM has no reset; stale contents are never read because occ gates pops.
        always_ff @(posedge sys_clock) begin
            if (push) begin
                mem[wr_ptr] <= s_axis.tdata[c*DATA_W +: DATA_W];
            end
            rd_data <= mem[rd_ptr];
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge sys_clock or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                pad    <= '0;
            end else if (cfg_load) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                pad    <= cfg_delay[c*DLY_W +: DLY_W];
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                unique case ({push, pop})
                    2'b10:   occ <= occ + OW'(1);
                    2'b01:   occ <= occ - OW'(1);
                    default: occ <= occ;
                endcase
                if (fetch && pad != '0) begin
                    pad <= pad - DLY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        handshake = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_ok) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                fetch     = 1'b1;
                state_nxt = VALID;
            end
            VALID: begin
                if (m_axis.tready[0]) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (cfg_load) begin
            fetch     = 1'b0;
            handshake = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            m_axis.tvalid <= '0;
            m_axis.tdata  <= '0;
            frame_cnt     <= '0;
        end else if (cfg_load) begin
            m_axis.tvalid <= '0;
            frame_cnt     <= '0;
        end else begin
            if (fetch) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= frame_data;
            end
            if (handshake) begin
                m_axis.tvalid <= 1'b0;
                frame_cnt     <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ecg_phase_align.sv
// Scoreboard bench for ecg_phase_align: expected frames are queued from the delay definition
// when stimulus starts and popped by a monitor on every output handshake.
module tb_ecg_phase_align;
    localparam int N_CH   = 3;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int DLY_W  = 10;
    localparam int FW     = N_CH * DATA_W;

    logic                  sys_clock;
    logic                  reset_n;
    logic [N_CH*DLY_W-1:0] cfg_delay;
    logic                  cfg_load;
    logic [15:0]           frame_cnt;

    ecg_phase_align_if #(.VALID_W(N_CH), .TDATA_W(FW)) s_if ();
    ecg_phase_align_if #(.VALID_W(1),    .TDATA_W(FW)) m_if ();

    ecg_phase_align #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .cfg_delay (cfg_delay),
        .cfg_load  (cfg_load),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .frame_cnt (frame_cnt)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    int              vectors = 0;
    int              miscompares = 0;
    int              exp_cnt = 0;
    bit              saw_valid = 1'b0;
    logic [FW-1:0]   exp_q [$];
    int              nxt [N_CH];
    int              rem [N_CH];

    function automatic logic [FW-1:0] mk(input int a0, input int a1, input int a2);
        return {DATA_W'(a2), DATA_W'(a1), DATA_W'(a0)};
    endfunction

    function automatic int dly(input int k, input int d);
        return (k >= d) ? k - d : 0;
    endfunction

    // Output monitor: a handshake is visible at the falling edge before the accepting edge.
    always @(negedge sys_clock) begin
        logic [FW-1:0] e;
        if (m_if.tvalid[0]) saw_valid = 1'b1;
        if (reset_n && m_if.tvalid[0] && m_if.tready[0]) begin
            vectors++;
            exp_cnt++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_unexpected got=%h expected=none", m_if.tdata);
            end else begin
                e = exp_q.pop_front();
                if (m_if.tdata !== e) begin
                    miscompares++;
                    $display("FAIL frame_data got=%h expected=%h", m_if.tdata, e);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_feed(input int b0, input int b1, input int b2,
                            input int n0, input int n1, input int n2);
        nxt[0] = b0; nxt[1] = b1; nxt[2] = b2;
        rem[0] = n0; rem[1] = n1; rem[2] = n2;
    endtask

    task automatic do_cfg(input int d0, input int d1, input int d2);
        cfg_delay = {DLY_W'(d2), DLY_W'(d1), DLY_W'(d0)};
        cfg_load  = 1'b1;
        @(posedge sys_clock); #1;
        cfg_load  = 1'b0;
        exp_q.delete();
        exp_cnt   = 0;
    endtask

    // Feeds every channel with pending samples, one offer per channel every gap+1 cycles.
    task automatic run_feed(input int gap, input int ncycles);
        int wait_c [N_CH];
        logic [N_CH-1:0] acc;
        for (int c = 0; c < N_CH; c++) wait_c[c] = 0;
        for (int cyc = 0; cyc < ncycles && (rem[0] + rem[1] + rem[2]) > 0; cyc++) begin
            for (int c = 0; c < N_CH; c++) begin
                s_if.tvalid[c] = (rem[c] > 0) && (wait_c[c] == 0);
                s_if.tdata[c*DATA_W +: DATA_W] = DATA_W'(nxt[c]);
            end
            @(negedge sys_clock);
            acc = s_if.tvalid & s_if.tready;
            @(posedge sys_clock); #1;
            for (int c = 0; c < N_CH; c++) begin
                if (acc[c]) begin
                    nxt[c]++;
                    rem[c]--;
                    wait_c[c] = gap;
                end else if (wait_c[c] > 0) begin
                    wait_c[c]--;
                end
            end
        end
        s_if.tvalid = '0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int cyc = 0;
        while (exp_q.size() != 0) begin
            if (cyc >= budget) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_drain got=%0d_left expected=0_left", name, exp_q.size());
                exp_q.delete();
                break;
            end
            @(posedge sys_clock); #1;
            cyc++;
        end
        repeat (2) @(posedge sys_clock);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int cyc = 0;
        while (!m_if.tvalid[0]) begin
            if (cyc >= budget) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_valid_timeout got=0 expected=1", name);
                break;
            end
            @(posedge sys_clock); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #22;
        vectors++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=v%b d%h c%0d expected=v0 d0 c0",
                     m_if.tvalid, m_if.tdata, frame_cnt);
        end
        vectors++;
        if (s_if.tready !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_tready got=%b expected=000", s_if.tready);
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (s_if.tready !== 3'b111) begin
            miscompares++;
            $display("FAIL release_tready got=%b expected=111", s_if.tready);
        end
        @(posedge sys_clock); #1;
    endtask

    task automatic test_delay_ramp();
        do_cfg(113, 18, 0);
        m_if.tready = 1'b1;
        for (int k = 0; k < 400; k++) exp_q.push_back(mk(dly(k, 113), dly(k, 18), k));
        set_feed(0, 0, 0, 400, 400, 400);
        run_feed(82, 400 * 83 + 100);
        wait_drain(200, "ramp");
        vectors++;
        if (frame_cnt !== 16'd400) begin
            miscompares++;
            $display("FAIL ramp_frame_cnt got=%0d expected=400", frame_cnt);
        end
    endtask

    task automatic test_skew();
        do_cfg(0, 0, 0);
        m_if.tready = 1'b1;
        saw_valid   = 1'b0;
        set_feed(0, 0, 0, 50, 50, 0);
        run_feed(0, 100);
        repeat (4) @(posedge sys_clock);
        #1;
        vectors++;
        if (saw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL skew_early_valid got=1 expected=0");
        end
        vectors++;
        if (dut.g_ch[0].occ !== 10'd50) begin
            miscompares++;
            $display("FAIL skew_occ0 got=%0d expected=50", dut.g_ch[0].occ);
        end
        for (int k = 0; k < 60; k++) exp_q.push_back(mk(k, k, k));
        rem[0] = 10; rem[1] = 10; rem[2] = 60;
        run_feed(0, 400);
        wait_drain(300, "skew");
    endtask

    task automatic test_full();
        do_cfg(0, 0, 0);
        m_if.tready = 1'b1;
        saw_valid   = 1'b0;
        set_feed(0, 0, 0, 600, 600, 0);
        run_feed(0, 700);
        vectors++;
        if (nxt[0] !== DEPTH || s_if.tready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ch0 got=pushed%0d rdy%b expected=pushed512 rdy0", nxt[0], s_if.tready[0]);
        end
        vectors++;
        if (saw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_early_valid got=1 expected=0");
        end
        for (int k = 0; k < 10; k++) exp_q.push_back(mk(k, k, k));
        rem[0] = 0; rem[1] = 0; rem[2] = 10;
        run_feed(0, 100);
        wait_drain(100, "full");
        vectors++;
        if (s_if.tready[0] !== 1'b1 || frame_cnt !== 16'd10) begin
            miscompares++;
            $display("FAIL full_recover got=rdy%b cnt%0d expected=rdy1 cnt10", s_if.tready[0], frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] want;
        do_cfg(0, 0, 0);
        m_if.tready = 1'b0;
        want = mk(32'h11, 32'h22, 32'h33);
        exp_q.push_back(want);
        set_feed(32'h11, 32'h22, 32'h33, 1, 1, 1);
        run_feed(0, 10);
        wait_valid(10, "stall");
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clock);
            vectors++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== want) begin
                miscompares++;
                $display("FAIL stall_hold got=v%b d%h expected=v1 d%h", m_if.tvalid, m_if.tdata, want);
            end
        end
        @(posedge sys_clock); #1;
        m_if.tready = 1'b1;
        wait_drain(10, "stall");
        vectors++;
        if (frame_cnt !== 16'd1 || m_if.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_count got=cnt%0d v%b expected=cnt1 v0", frame_cnt, m_if.tvalid);
        end
    endtask

    task automatic test_cfg_mid_frame();
        do_cfg(0, 0, 0);
        m_if.tready = 1'b0;
        set_feed(100, 200, 300, 8, 1, 1);
        run_feed(0, 20);
        wait_valid(10, "cfg");
        vectors++;
        if (dut.g_ch[0].occ !== 10'd7) begin
            miscompares++;
            $display("FAIL cfg_pre_occ0 got=%0d expected=7", dut.g_ch[0].occ);
        end
        do_cfg(5, 0, 0);
        vectors++;
        if (m_if.tvalid !== 1'b0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL cfg_clear got=v%b cnt%0d expected=v0 cnt0", m_if.tvalid, frame_cnt);
        end
        vectors++;
        if (dut.g_ch[0].occ !== 10'd0 || dut.g_ch[1].occ !== 10'd0 || dut.g_ch[2].occ !== 10'd0) begin
            miscompares++;
            $display("FAIL cfg_occ got=%0d,%0d,%0d expected=0,0,0",
                     dut.g_ch[0].occ, dut.g_ch[1].occ, dut.g_ch[2].occ);
        end
        for (int k = 0; k < 10; k++) exp_q.push_back(mk(dly(k, 5), k, k));
        m_if.tready = 1'b1;
        set_feed(0, 0, 0, 10, 10, 10);
        run_feed(2, 200);
        wait_drain(100, "cfg");
    endtask

    task automatic test_async_reset();
        int lat;
        do_cfg(3, 0, 0);
        m_if.tready = 1'b0;
        set_feed(7, 8, 9, 1, 1, 1);
        run_feed(0, 10);
        wait_valid(10, "arst");
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        vectors++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || frame_cnt !== 16'd0 || s_if.tready !== 3'b000) begin
            miscompares++;
            $display("FAIL arst_outputs got=v%b d%h c%0d r%b expected=v0 d0 c0 r000",
                     m_if.tvalid, m_if.tdata, frame_cnt, s_if.tready);
        end
        #9 reset_n = 1'b1;
        @(posedge sys_clock); #1;
        m_if.tready = 1'b1;
        exp_q.push_back(mk(100, 101, 102));
        s_if.tvalid = 3'b111;
        s_if.tdata  = mk(100, 101, 102);
        @(posedge sys_clock); #1;
        s_if.tvalid = '0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_if.tvalid[0]) break;
            @(posedge sys_clock); #1;
            lat++;
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL arst_latency got=%0d expected=2", lat);
        end
        wait_drain(10, "arst");
    endtask

    initial begin
        reset_n      = 1'b0;
        cfg_load     = 1'b0;
        cfg_delay    = '0;
        s_if.tvalid  = '0;
        s_if.tdata   = '0;
        m_if.tready  = 1'b1;
        test_reset();
        test_delay_ramp();
        test_skew();
        test_full();
        test_backpressure();
        test_cfg_mid_frame();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
